// File: rtl/adi_jesd_snapshot.sv
// adi_jesd_snapshot
//
// Snapshot capture buffer for the JESD204C receive data stream. When armed,
// it stores a programmable number of consecutive valid 512-bit words into
// block RAM. Capture starts either at the first valid word or at the first
// sync-flagged valid word. Software reads the buffer back 32 bits at a time.
//
// Ports:
//   i_clk              link/user clock; everything runs on its rising edge
//   i_rst              synchronous active-high reset
//   i_din              sample word (16 lanes of 32 bits)
//   i_din_vld          word qualifier
//   i_din_sync         frame/multiframe marker, qualified by i_din_vld
//   i_din_overflow     upstream overflow flag
//   i_arm              level input; a rising edge starts a capture
//   i_trig_sel         0: immediate start, 1: start on sync (sampled on arm edge)
//   i_capture_len      words to capture; 0 or > depth means full depth
//   i_rd_addr          [3:0] selects the 32-bit lane, upper bits the word index
//   o_rd_data          read data, two cycles after i_rd_addr
//   o_busy             waiting for trigger or capturing
//   o_done             capture complete
//   o_ovf_seen         sticky upstream overflow seen during capture
//   o_words_captured   running write count
//   o_ts               trigger timestamp (0 unless timestamping is built)
//
// Optional feature: define ADI_JESD_SNAP_TIMESTAMP_EN to build a free-running
// valid-word counter whose value on the trigger cycle is latched into o_ts.

module adi_jesd_snapshot #(
    parameter int unsigned DIN_W      = 512,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DIN_W-1:0]      i_din,
    input  logic                  i_din_vld,
    input  logic                  i_din_sync,
    input  logic                  i_din_overflow,
    input  logic                  i_arm,
    input  logic                  i_trig_sel,
    input  logic [DEPTH_LOG2:0]   i_capture_len,
    input  logic [DEPTH_LOG2+3:0] i_rd_addr,
    output logic [31:0]           o_rd_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ovf_seen,
    output logic [DEPTH_LOG2:0]   o_words_captured,
    output logic [31:0]           o_ts
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEN_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StWaitTrig,
        StCapture,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic                r_arm_q;
    logic                r_trig_sel;
    logic [DEPTH_LOG2:0] r_len;
    logic [DEPTH_LOG2:0] r_words;
    logic                r_ovf_seen;

    logic                w_arm_edge;
    logic                w_accept;
    logic                w_trig;
    logic                w_we;
    logic [DEPTH_LOG2:0] w_words_inc;
    logic [DEPTH_LOG2:0] w_len_clamped;

    assign w_arm_edge    = i_arm & ~r_arm_q;
    assign w_words_inc   = r_words + LEN_ONE;
    assign w_len_clamped = ((i_capture_len == '0) || (i_capture_len > DEPTH_W)) ?
                           DEPTH_W : i_capture_len;

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        w_trig    = 1'b0;
        w_we      = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_arm_edge) begin
                    w_accept  = 1'b1;
                    w_state_d = StWaitTrig;
                end
            end
            StWaitTrig: begin
                if (i_din_vld && (!r_trig_sel || i_din_sync)) begin
                    w_trig    = 1'b1;
                    w_we      = 1'b1;
                    w_state_d = (r_len == LEN_ONE) ? StDone : StCapture;
                end
            end
            StCapture: begin
                if (i_din_vld) begin
                    w_we = 1'b1;
                    if (w_words_inc == r_len) begin
                        w_state_d = StDone;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_arm_q    <= 1'b0;
            r_trig_sel <= 1'b0;
            r_len      <= '0;
            r_words    <= '0;
            r_ovf_seen <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_arm_q <= i_arm;
            if (w_accept) begin
                r_trig_sel <= i_trig_sel;
                r_len      <= w_len_clamped;
                r_words    <= '0;
                r_ovf_seen <= 1'b0;
            end
            if (w_we) begin
                r_words <= w_words_inc;
            end
            // The trigger cycle counts as part of the capture window.
            if (i_din_overflow && ((r_state == StCapture) || w_trig)) begin
                r_ovf_seen <= 1'b1;
            end
        end
    end

    // Simple dual-port buffer; contents survive reset.
    logic [DIN_W-1:0] r_mem [DEPTH];
    logic [DIN_W-1:0] r_ram_q;
    logic [3:0]       r_lane_q;
    logic [31:0]      r_rd_data;

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[r_words[DEPTH_LOG2-1:0]] <= i_din;
        end
        r_ram_q  <= r_mem[i_rd_addr[DEPTH_LOG2+3:4]];
        // Lane select is delayed to line up with the RAM output register.
        r_lane_q <= i_rd_addr[3:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_ram_q[{r_lane_q, 5'b0} +: 32];
        end
    end

`ifdef ADI_JESD_SNAP_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_ts;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ts_cnt <= '0;
            r_ts     <= '0;
        end else begin
            if (i_din_vld) begin
                r_ts_cnt <= r_ts_cnt + 32'd1;
            end
            if (w_trig) begin
                r_ts <= r_ts_cnt;
            end
        end
    end

    assign o_ts = r_ts;
`else
    assign o_ts = '0;
`endif

    assign o_rd_data        = r_rd_data;
    assign o_busy           = (r_state == StWaitTrig) || (r_state == StCapture);
    assign o_done           = (r_state == StDone);
    assign o_ovf_seen       = r_ovf_seen;
    assign o_words_captured = r_words;

endmodule

// File: tb/tb_adi_jesd_snapshot.sv
// Directed testbench for adi_jesd_snapshot (DEPTH_LOG2 = 4, 16-word buffer).
// Every lane of a stimulus word carries tag*256 + lane so readback values can
// be computed by hand.

module tb_adi_jesd_snapshot;

    localparam int unsigned DIN_W      = 512;
    localparam int unsigned DEPTH_LOG2 = 4;

    logic                  clk;
    logic                  rst;
    logic [DIN_W-1:0]      din;
    logic                  din_vld;
    logic                  din_sync;
    logic                  din_overflow;
    logic                  arm;
    logic                  trig_sel;
    logic [DEPTH_LOG2:0]   capture_len;
    logic [DEPTH_LOG2+3:0] rd_addr;
    logic [31:0]           rd_data;
    logic                  busy;
    logic                  done;
    logic                  ovf_seen;
    logic [DEPTH_LOG2:0]   words_captured;
    logic [31:0]           ts;

    int n_checks = 0;
    int n_errors = 0;

    adi_jesd_snapshot #(
        .DIN_W      (DIN_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_din            (din),
        .i_din_vld        (din_vld),
        .i_din_sync       (din_sync),
        .i_din_overflow   (din_overflow),
        .i_arm            (arm),
        .i_trig_sel       (trig_sel),
        .i_capture_len    (capture_len),
        .i_rd_addr        (rd_addr),
        .o_rd_data        (rd_data),
        .o_busy           (busy),
        .o_done           (done),
        .o_ovf_seen       (ovf_seen),
        .o_words_captured (words_captured),
        .o_ts             (ts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIN_W-1:0] mk_word(input int tag);
        logic [DIN_W-1:0] w;
        for (int n = 0; n < 16; n++) begin
            w[32*n +: 32] = 32'(tag * 256 + n);
        end
        return w;
    endfunction

    task automatic read_chk(input string tag, input int addr, input int exp);
        rd_addr = (DEPTH_LOG2 + 4)'(addr);
        tick();
        tick();
        check_eq(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic arm_pulse(input logic sel, input int len);
        trig_sel    = sel;
        capture_len = (DEPTH_LOG2 + 1)'(len);
        arm         = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        din          = '0;
        din_vld      = 1'b0;
        din_sync     = 1'b0;
        din_overflow = 1'b0;
        arm          = 1'b0;
        trig_sel     = 1'b0;
        capture_len  = '0;
        rd_addr      = '0;
        tick();
        tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_ovf", 64'(ovf_seen), 64'd0);
        check_eq("rst_words", 64'(words_captured), 64'd0);
        check_eq("rst_ts", 64'(ts), 64'd0);
        check_eq("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        tick();

        // Immediate capture, L=4, din_vld always high.
        arm_pulse(1'b0, 4);
        check_eq("imm_busy_after_arm", 64'(busy), 64'd1);
        check_eq("imm_words_after_arm", 64'(words_captured), 64'd0);
        for (int i = 0; i < 4; i++) begin
            din     = mk_word(i);
            din_vld = 1'b1;
            tick();
            check_eq("imm_words", 64'(words_captured), 64'(i + 1));
            check_eq("imm_done", 64'(done), 64'(i == 3));
            check_eq("imm_busy", 64'(busy), 64'(i != 3));
        end
        din = mk_word(99);
        tick();
        din_vld = 1'b0;
        check_eq("imm_words_hold", 64'(words_captured), 64'd4);
        read_chk("rd_0x23", 'h23, 2 * 256 + 3);
        read_chk("rd_0x00", 'h00, 0);
        read_chk("rd_0x3f", 'h3f, 3 * 256 + 15);
        read_chk("rd_0x10", 'h10, 1 * 256);

        // Sync trigger on the 5th valid word, valid toggling 1/0. Sync and
        // overflow on invalid/waiting cycles must have no effect.
        arm_pulse(1'b1, 8);
        check_eq("sync_busy_after_arm", 64'(busy), 64'd1);
        check_eq("sync_done_cleared", 64'(done), 64'd0);
        check_eq("sync_words_cleared", 64'(words_captured), 64'd0);
        for (int v = 0; v < 16; v++) begin
            din          = mk_word(100 + v);
            din_vld      = 1'b1;
            din_sync     = (v == 4);
            din_overflow = 1'b0;
            tick();
            din          = mk_word('hEE);
            din_vld      = 1'b0;
            din_sync     = (v < 4);
            din_overflow = (v == 1);
            tick();
            if (v == 3) begin
                check_eq("sync_wait_words", 64'(words_captured), 64'd0);
                check_eq("sync_wait_busy", 64'(busy), 64'd1);
            end
        end
        din_sync     = 1'b0;
        din_overflow = 1'b0;
        check_eq("sync_words", 64'(words_captured), 64'd8);
        check_eq("sync_done", 64'(done), 64'd1);
        check_eq("sync_ovf", 64'(ovf_seen), 64'd0);
        read_chk("sync_rd_w0", 'h00, 104 * 256);
        read_chk("sync_rd_w3", 'h33, 107 * 256 + 3);
        read_chk("sync_rd_w7", 'h77, 111 * 256 + 7);

        // Arm edge while capturing is ignored; reset mid-capture.
        arm_pulse(1'b0, 8);
        for (int i = 0; i < 3; i++) begin
            din     = mk_word(200 + i);
            din_vld = 1'b1;
            arm     = (i == 2);
            tick();
        end
        check_eq("busy_arm_ignored_words", 64'(words_captured), 64'd3);
        check_eq("busy_arm_ignored_busy", 64'(busy), 64'd1);
        din_vld = 1'b0;
        arm     = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_words", 64'(words_captured), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        check_eq("midrst_rd_data", 64'(rd_data), 64'd0);
        read_chk("midrst_rd_w0", 'h00, 200 * 256);
        read_chk("midrst_rd_w2", 'h21, 202 * 256 + 1);

        // Length 0 clamps to 16; overflow pulse mid-capture; arm held high.
        trig_sel    = 1'b0;
        capture_len = '0;
        arm         = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            din          = mk_word(300 + i);
            din_vld      = 1'b1;
            din_overflow = (i == 5);
            tick();
            if (i == 4) check_eq("clamp_ovf_before", 64'(ovf_seen), 64'd0);
            if (i == 5) check_eq("clamp_ovf_after", 64'(ovf_seen), 64'd1);
        end
        din_overflow = 1'b0;
        check_eq("clamp_words", 64'(words_captured), 64'd16);
        check_eq("clamp_done", 64'(done), 64'd1);
        for (int i = 0; i < 3; i++) begin
            din = mk_word(350 + i);
            tick();
        end
        check_eq("held_arm_words", 64'(words_captured), 64'd16);
        check_eq("held_arm_done", 64'(done), 64'd1);
        check_eq("held_arm_busy", 64'(busy), 64'd0);
        din_vld = 1'b0;
        read_chk("clamp_rd_w15", 'hff, 315 * 256 + 15);
        arm = 1'b0;
        tick();

        // L=1 goes straight to DONE; overflow on the trigger cycle counts.
        arm_pulse(1'b0, 1);
        check_eq("rearm_ovf_cleared", 64'(ovf_seen), 64'd0);
        check_eq("rearm_words_cleared", 64'(words_captured), 64'd0);
        check_eq("rearm_busy", 64'(busy), 64'd1);
        din          = mk_word(400);
        din_vld      = 1'b1;
        din_overflow = 1'b1;
        tick();
        din_vld      = 1'b0;
        din_overflow = 1'b0;
        check_eq("len1_done", 64'(done), 64'd1);
        check_eq("len1_words", 64'(words_captured), 64'd1);
        check_eq("len1_trig_ovf", 64'(ovf_seen), 64'd1);

        // Length above depth clamps to 16.
        arm_pulse(1'b0, 20);
        for (int i = 0; i < 17; i++) begin
            din     = mk_word(500 + i);
            din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
        check_eq("over_len_words", 64'(words_captured), 64'd16);
        check_eq("over_len_done", 64'(done), 64'd1);

        // Timestamp: 100 valid cycles after reset, then trigger.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
        arm_pulse(1'b0, 1);
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        check_eq("ts_done", 64'(done), 64'd1);
`ifdef ADI_JESD_SNAP_TIMESTAMP_EN
        check_eq("ts_value", 64'(ts), 64'd100);
`else
        check_eq("ts_value", 64'(ts), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adi_jesd_snapshot.md
# adi_jesd_snapshot

Snapshot capture buffer directly downstream of the JESD204C receive top level. It consumes the 512-bit `dout`/`dout_vld`/`dout_sync`/`dout_overflow` stream in the link clock domain. When armed, it stores a programmable number of consecutive valid words in on-chip block RAM, starting either immediately or at the next sync-flagged word. Software then reads the buffer back 32 bits at a time through a registered read port.

## Interface
Parameters:
- `DIN_W`, 512 — input word width; must equal 16 × 32.
- `DEPTH_LOG2`, 10 — log2 of buffer depth in 512-bit words (default 1024 words).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — link/user clock; all logic runs on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `din` in DIN_W — sample word from the JESD top `dout`.
- `din_vld` in 1 — word qualifier.
- `din_sync` in 1 — frame/multiframe marker, qualified by `din_vld`.
- `din_overflow` in 1 — upstream overflow flag.
- `arm` in 1 — level input; a rising edge starts a capture.
- `trig_sel` in 1 — 0 selects immediate start; 1 selects start on sync. Sampled on the arm edge.
- `capture_len` in DEPTH_LOG2+1 — number of words to capture. Sampled on the arm edge.
- `rd_addr` in DEPTH_LOG2+4 — read address; `[3:0]` is the 32-bit lane, the upper bits are the word index.
- `rd_data` out 32 — read data.
- `busy` out 1 — high in WAIT_TRIG or CAPTURE.
- `done` out 1 — high in DONE.
- `ovf_seen` out 1 — sticky upstream overflow seen during CAPTURE.
- `words_captured` out DEPTH_LOG2+1 — running write count.
- `ts` out 32 — trigger timestamp; see Configuration.

## Operation
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- Arm edge detect: `arm_q` is registered; an edge is `arm & ~arm_q`. Edges are ignored in WAIT_TRIG and CAPTURE. They are accepted in IDLE and DONE.
- Accepted edge:
  - latch `trig_sel`;
  - latch length L = `capture_len` clamped to [1, 2^DEPTH_LOG2]; 0 and values above depth both become 2^DEPTH_LOG2;
  - clear `words_captured`, `ovf_seen`, `done`;
  - go to WAIT_TRIG.
- WAIT_TRIG:
  - trig_sel=0: the first cycle with `din_vld`=1 is the trigger.
  - trig_sel=1: the first cycle with `din_vld & din_sync` is the trigger.
  - The trigger word itself is written at address 0. State becomes CAPTURE, or DONE if L=1.
- CAPTURE:
  - each `din_vld` cycle writes `din` at address `words_captured` and increments the count;
  - cycles with `din_vld`=0 write nothing;
  - when the write brings the count to L, go to DONE.
- `ovf_seen` is set by `din_overflow`=1 on any cycle in which the state is CAPTURE, and on the trigger cycle.
- DONE holds until the next accepted arm edge. Buffer contents are retained.
- Memory: simple dual-port, DIN_W × 2^DEPTH_LOG2.
  - Write port: the word.
  - Read port: indexed by `rd_addr[DEPTH_LOG2+3:4]`.
  - Lane mux: lane n = `din[32n+31:32n]`.
- Reads are legal in any state. Reading during a capture returns old or new data without error.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `ovf_seen`=0, `words_captured`=0, `ts`=0, `rd_data`=0, `arm_q`=0. RAM contents are not reset.
- An arm edge sampled at cycle t gives `busy`=1 from t+1. The earliest trigger/write is in cycle t+1.
- A write in cycle k makes `words_captured` visible at k+1.
- Last write in cycle k gives `done`=1 and `busy`=0 from k+1.
- Read latency: `rd_addr` presented at cycle t gives `rd_data` at t+2 (RAM output register plus lane-mux register).
- `rst` mid-capture: the next cycle is IDLE with all outputs at reset values. Partial data stays in RAM.
- `arm` held high through DONE: no re-trigger. A fresh 0→1 transition is required.

## Configuration
- `ADI_JESD_SNAP_TIMESTAMP_EN` defined:
  - a 32-bit free-running counter increments on every `din_vld` cycle, wrapping at 2^32;
  - its value in the trigger cycle is latched into `ts`;
  - `ts` is held until the next trigger and cleared by `rst`.
- Not defined: `ts` is tied to 0 and no counter is built.

## Test plan
- **Immediate capture:** arm with trig_sel=0, L=4, `din` = word index pattern, `din_vld` always 1 → 4 words stored at addresses 0–3, `done`=1 four cycles after first write, `words_captured`=4.
- **Sync trigger with gaps:** trig_sel=1, L=8, sync on the 5th valid word, `din_vld` toggling 1/0 → RAM[0] = 5th valid word, 8 consecutive valid words stored, invalid cycles skipped.
- **Readback:** after capture, read `rd_addr` = 0x23 → at t+2, `rd_data` = `din[127:96]` of word 2.
- **Length clamp and overflow:** `capture_len`=0 with DEPTH_LOG2=4 → 16 words captured. A 1-cycle `din_overflow` pulse mid-capture gives `ovf_seen`=1, cleared on the next arm edge.
- **Reset and re-arm:** `rst` after 3 of 8 words → IDLE, `busy`=0, count 0. An arm edge while busy is ignored. An arm held high after `done` does not restart.
- **Timestamp (macro on):** 100 valid cycles after reset, then trigger → `ts`=100. With the macro off → `ts`=0.
